// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle between the data path, the load/store controller and the data SRAM.
// The controller connects through the slave modport; the surrounding CPU/SRAM
// environment uses the master modport.
// Optional macro DMEM_MISALIGN_TRAP_EN adds the MEM_misaligned strobe.
interface dmem_access_ctrl_if #(
   parameter int ADDR_W = 10
);
   // data path request side
   logic              MEM_read_en;
   logic [1:0]        MEM_read_length;
   logic              MEM_read_signed;
   logic [31:0]       MEM_read_address;
   logic [1:0]        MEM_write_length;
   logic [31:0]       MEM_write_data;
   logic [31:0]       MEM_write_address;
   logic [31:0]       MEM_read_data;
   logic              MEM_stall;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic              MEM_misaligned;
`endif
   // SRAM side
   logic              SRAM_en;
   logic              SRAM_we;
   logic [ADDR_W-1:0] SRAM_addr;
   logic [3:0]        SRAM_be;
   logic [31:0]       SRAM_wdata;
   logic [31:0]       SRAM_rdata;

   modport slave (
`ifdef DMEM_MISALIGN_TRAP_EN
      output MEM_misaligned,
`endif
      input  MEM_read_en,
      input  MEM_read_length,
      input  MEM_read_signed,
      input  MEM_read_address,
      input  MEM_write_length,
      input  MEM_write_data,
      input  MEM_write_address,
      output MEM_read_data,
      output MEM_stall,
      output SRAM_en,
      output SRAM_we,
      output SRAM_addr,
      output SRAM_be,
      output SRAM_wdata,
      input  SRAM_rdata
   );

   modport master (
`ifdef DMEM_MISALIGN_TRAP_EN
      input  MEM_misaligned,
`endif
      output MEM_read_en,
      output MEM_read_length,
      output MEM_read_signed,
      output MEM_read_address,
      output MEM_write_length,
      output MEM_write_data,
      output MEM_write_address,
      input  MEM_read_data,
      input  MEM_stall,
      input  SRAM_en,
      input  SRAM_we,
      input  SRAM_addr,
      input  SRAM_be,
      input  SRAM_wdata,
      output SRAM_rdata
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store unit: turns byte/half/word requests at arbitrary byte addresses
// into word-aligned SRAM accesses with byte enables, splits accesses that
// straddle a word boundary into two SRAM cycles, and sign/zero-extends loads.
// MEM_stall holds the PC while a multi-cycle access is in flight.
// Optional macro DMEM_MISALIGN_TRAP_EN: straddling requests are not performed
// and flagged on MEM_misaligned instead.
module dmem_access_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic               SYS_clk,
   input  logic               SYS_reset_n,
   dmem_access_ctrl_if.slave  bus
);

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD1  = 3'd1,
      ST_RD2  = 3'd2,
      ST_WR2  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Byte count of a length code; code 0 means a full word.
   function automatic logic [2:0] len_to_nbytes(input logic [1:0] len);
      case (len)
         2'd1:    return 3'd1;
         2'd2:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Unshifted lane mask for an access of nb bytes.
   function automatic logic [3:0] lane_mask(input logic [2:0] nb);
      case (nb)
         3'd1:    return 4'b0001;
         3'd2:    return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Truncate to nb bytes and extend; full words pass through untouched.
   function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                               input logic [2:0]  nb,
                                               input logic        sgn);
      case (nb)
         3'd1: begin
            if (sgn) return {{24{raw[7]}}, raw[7:0]};
            else     return {24'd0, raw[7:0]};
         end
         3'd2: begin
            if (sgn) return {{16{raw[15]}}, raw[15:0]};
            else     return {16'd0, raw[15:0]};
         end
         default: return raw;
      endcase
   endfunction

   state_t              state_r;
   state_t              state_nxt_s;

   // request captured on acceptance in IDLE
   logic [ADDR_W+1:0]   req_addr_r;
   logic [2:0]          req_nb_r;
   logic                req_signed_r;
   logic [31:0]         req_wdata_r;
   logic                req_split_r;

   logic [31:0]         buf0_r;
   logic [31:0]         buf1_r;
   logic [31:0]         read_data_r;

   // decode of the live request seen in IDLE
   logic                rd_req_s;
   logic                wr_req_s;
   logic [ADDR_W+1:0]   in_addr_s;
   logic [2:0]          in_nb_s;

   // geometry of the request being worked on (live in IDLE, captured after)
   logic [ADDR_W+1:0]   cur_addr_s;
   logic [2:0]          cur_nb_s;
   logic [31:0]         cur_wdata_s;
   logic [1:0]          off_s;
   logic [ADDR_W-1:0]   word0_s;
   logic [ADDR_W-1:0]   word1_s;
   logic                split_s;
   logic [7:0]          be_wide_s;
   logic [63:0]         wd_wide_s;

   // load assembly
   logic [63:0]         pair_s;
   logic [63:0]         pair_shift_s;
   logic [31:0]         load_ext_s;

   // raw (pre-reset-gating) outputs
   logic                sram_en_s;
   logic                sram_we_s;
   logic [ADDR_W-1:0]   sram_addr_s;
   logic [3:0]          sram_be_s;
   logic [31:0]         sram_wdata_s;
   logic                stall_s;
   logic                mis_s;

   assign rd_req_s = bus.MEM_read_en;
   assign wr_req_s = (bus.MEM_read_en == 1'b0) && (bus.MEM_write_length != 2'd0);

   // Select address and size of the live request; a load wins over a store.
   always_comb begin
      in_addr_s = bus.MEM_write_address[ADDR_W+1:0];
      in_nb_s   = len_to_nbytes(bus.MEM_write_length);
      if (rd_req_s) begin
         in_addr_s = bus.MEM_read_address[ADDR_W+1:0];
         in_nb_s   = len_to_nbytes(bus.MEM_read_length);
      end else begin
         in_addr_s = bus.MEM_write_address[ADDR_W+1:0];
         in_nb_s   = len_to_nbytes(bus.MEM_write_length);
      end
   end

   // Work on the live request in IDLE and on the captured copy afterwards.
   always_comb begin
      cur_addr_s  = req_addr_r;
      cur_nb_s    = req_nb_r;
      cur_wdata_s = req_wdata_r;
      if (state_r == ST_IDLE) begin
         cur_addr_s  = in_addr_s;
         cur_nb_s    = in_nb_s;
         cur_wdata_s = bus.MEM_write_data;
      end else begin
         cur_addr_s  = req_addr_r;
         cur_nb_s    = req_nb_r;
         cur_wdata_s = req_wdata_r;
      end
   end

   assign off_s     = cur_addr_s[1:0];
   assign word0_s   = cur_addr_s[ADDR_W+1:2];
   assign word1_s   = word0_s + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign split_s   = ({2'b00, off_s} + {1'b0, cur_nb_s}) > 4'd4;
   // low nibble/word go to word0, high nibble/word spill into word1
   assign be_wide_s = {4'b0000, lane_mask(cur_nb_s)} << off_s;
   assign wd_wide_s = {32'd0, cur_wdata_s} << {off_s, 3'b000};

   // Pair the two read words; RD1 completes only unsplit loads, RD2 the split ones.
   always_comb begin
      pair_s = 64'd0;
      case (state_r)
         ST_RD1:  pair_s = {buf1_r, bus.SRAM_rdata};
         ST_RD2:  pair_s = {bus.SRAM_rdata, buf0_r};
         default: pair_s = {buf1_r, buf0_r};
      endcase
   end

   assign pair_shift_s = pair_s >> {off_s, 3'b000};
   assign load_ext_s   = extend_load(pair_shift_s[31:0], cur_nb_s, req_signed_r);

   // State register.
   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (rd_req_s) begin
               state_nxt_s = ST_RD1;
            end else if (wr_req_s && split_s && !TRAP_EN) begin
               state_nxt_s = ST_WR2;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RD1: begin
            if (req_split_r && !TRAP_EN) begin
               state_nxt_s = ST_RD2;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         ST_RD2:  state_nxt_s = ST_DONE;
         ST_WR2:  state_nxt_s = ST_IDLE;
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode: SRAM strobes, stall and misalignment flag per state.
   always_comb begin
      sram_en_s    = 1'b0;
      sram_we_s    = 1'b0;
      sram_addr_s  = word0_s;
      sram_be_s    = 4'b0000;
      sram_wdata_s = 32'd0;
      stall_s      = 1'b0;
      mis_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rd_req_s) begin
               stall_s = 1'b1;
               if (split_s && TRAP_EN) begin
                  mis_s = 1'b1;
               end else begin
                  sram_en_s   = 1'b1;
                  sram_addr_s = word0_s;
               end
            end else if (wr_req_s) begin
               if (split_s && TRAP_EN) begin
                  mis_s = 1'b1;
               end else begin
                  sram_en_s    = 1'b1;
                  sram_we_s    = 1'b1;
                  sram_addr_s  = word0_s;
                  sram_be_s    = be_wide_s[3:0];
                  sram_wdata_s = wd_wide_s[31:0];
                  stall_s      = split_s;
               end
            end else begin
               sram_en_s = 1'b0;
            end
         end
         ST_RD1: begin
            stall_s = 1'b1;
            if (req_split_r && !TRAP_EN) begin
               sram_en_s   = 1'b1;
               sram_addr_s = word1_s;
            end else begin
               sram_en_s = 1'b0;
            end
         end
         ST_RD2: begin
            stall_s = 1'b1;
         end
         ST_WR2: begin
            sram_en_s    = 1'b1;
            sram_we_s    = 1'b1;
            sram_addr_s  = word1_s;
            sram_be_s    = be_wide_s[7:4];
            sram_wdata_s = wd_wide_s[63:32];
         end
         ST_DONE: begin
            stall_s = 1'b0;
         end
         default: begin
            stall_s = 1'b0;
         end
      endcase
   end

   // Capture the accepted request so later states do not depend on held inputs.
   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         req_addr_r   <= '0;
         req_nb_r     <= 3'd4;
         req_signed_r <= 1'b0;
         req_wdata_r  <= 32'd0;
         req_split_r  <= 1'b0;
      end else if ((state_r == ST_IDLE) && (rd_req_s || wr_req_s)) begin
         req_addr_r   <= in_addr_s;
         req_nb_r     <= in_nb_s;
         req_signed_r <= bus.MEM_read_signed;
         req_wdata_r  <= bus.MEM_write_data;
         req_split_r  <= split_s;
      end else begin
         req_addr_r   <= req_addr_r;
      end
   end

   // Word buffers fed by the SRAM the cycle after each read strobe.
   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         buf0_r <= 32'd0;
         buf1_r <= 32'd0;
      end else if (state_r == ST_RD1) begin
         buf0_r <= bus.SRAM_rdata;
      end else if (state_r == ST_RD2) begin
         buf1_r <= bus.SRAM_rdata;
      end else begin
         buf0_r <= buf0_r;
      end
   end

   // Load result register, updated only on entry to DONE.
   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         read_data_r <= 32'd0;
      end else if ((state_r == ST_RD1) && (state_nxt_s == ST_DONE)) begin
         read_data_r <= (req_split_r && TRAP_EN) ? 32'd0 : load_ext_s;
      end else if (state_r == ST_RD2) begin
         read_data_r <= load_ext_s;
      end else begin
         read_data_r <= read_data_r;
      end
   end

   // While reset is low every strobe is forced inactive whatever the inputs.
   assign bus.SRAM_en       = sram_en_s & SYS_reset_n;
   assign bus.SRAM_we       = sram_we_s & SYS_reset_n;
   assign bus.SRAM_be       = sram_be_s & {4{SYS_reset_n}};
   assign bus.SRAM_addr     = sram_addr_s;
   assign bus.SRAM_wdata    = sram_wdata_s;
   assign bus.MEM_stall     = stall_s & SYS_reset_n;
   assign bus.MEM_read_data = read_data_r;

`ifdef DMEM_MISALIGN_TRAP_EN
   assign bus.MEM_misaligned = mis_s & SYS_reset_n;
`else
   logic unused_mis_s;
   assign unused_mis_s = mis_s;
`endif

   // Byte-address bits above the SRAM range wrap and are deliberately ignored.
   logic unused_bits_s;
   assign unused_bits_s = ^{bus.MEM_read_address[31:ADDR_W+2],
                            bus.MEM_write_address[31:ADDR_W+2],
                            pair_shift_s[63:32]};

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural word SRAM.
// Stimulus pushes expected SRAM strobes, stall lengths and load results into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_dmem_access_ctrl;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [3:0]        be;
      logic [31:0]       wdata;
   } sram_exp_t;

   logic SYS_clk = 1'b0;
   logic SYS_reset_n;
   always #5 SYS_clk = ~SYS_clk;

   dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
      .SYS_clk     (SYS_clk),
      .SYS_reset_n (SYS_reset_n),
      .bus         (bus)
   );

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   sram_exp_t   sram_q[$];
   int          stall_q[$];
   logic [31:0] load_q[$];
   int          mis_q[$];

   // behavioural SRAM: read data appears the cycle after the strobe
   logic [31:0] mem [0:DEPTH-1];
   logic [31:0] sram_rdata_r = 32'd0;
   logic        init_done = 1'b0;
   assign bus.SRAM_rdata = sram_rdata_r;

   always @(posedge SYS_clk) begin
      if (!init_done) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
         mem[0]    <= 32'h0000_00F0;
         mem[5]    <= 32'hCAFE_F00D;
         mem[1023] <= 32'hA500_0000;
         init_done <= 1'b1;
      end else if (bus.SRAM_en) begin
         if (bus.SRAM_we) begin
            for (int b = 0; b < 4; b++)
               if (bus.SRAM_be[b]) mem[bus.SRAM_addr][8*b +: 8] <= bus.SRAM_wdata[8*b +: 8];
         end else begin
            sram_rdata_r <= mem[bus.SRAM_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: compare every SRAM strobe, every stall run and every load completion
   initial begin
      int        stall_run;
      sram_exp_t e;
      stall_run = 0;
      forever begin
         @(negedge SYS_clk);
         if (!mon_en || !SYS_reset_n) begin
            stall_run = 0;
         end else begin
            if (bus.SRAM_en) begin
               if (sram_q.size() == 0) begin
                  chk("sram_unexpected_strobe_addr", 32'(bus.SRAM_addr), 32'hFFFF_FFFF);
               end else begin
                  e = sram_q.pop_front();
                  chk("sram_we", 32'(bus.SRAM_we), 32'(e.we));
                  chk("sram_addr", 32'(bus.SRAM_addr), 32'(e.addr));
                  if (e.we) begin
                     chk("sram_be", 32'(bus.SRAM_be), 32'(e.be));
                     chk("sram_wdata", bus.SRAM_wdata, e.wdata);
                  end
               end
            end
`ifdef DMEM_MISALIGN_TRAP_EN
            if (bus.MEM_misaligned) begin
               if (mis_q.size() == 0) chk("misaligned_unexpected", 32'd1, 32'd0);
               else chk("misaligned_pulse", 32'(bus.MEM_misaligned), 32'(mis_q.pop_front()));
            end
`endif
            if (bus.MEM_stall) begin
               stall_run++;
            end else if (stall_run > 0) begin
               if (stall_q.size() == 0) chk("stall_unexpected", 32'(stall_run), 32'd0);
               else chk("stall_cycles", 32'(stall_run), 32'(stall_q.pop_front()));
               if (bus.MEM_read_en) begin
                  if (load_q.size() == 0) chk("load_unexpected", bus.MEM_read_data, 32'hFFFF_FFFF);
                  else chk("load_data", bus.MEM_read_data, load_q.pop_front());
               end
               stall_run = 0;
            end
         end
      end
   end

   function automatic sram_exp_t mk(input logic we, input logic [ADDR_W-1:0] a,
                                    input logic [3:0] be, input logic [31:0] wd);
      sram_exp_t e;
      e.we = we; e.addr = a; e.be = be; e.wdata = wd;
      return e;
   endfunction

   // hold the request until the access completes (stall low), then drop it
   task automatic finish_op();
      bit done = 1'b0;
      for (int n = 0; n < 12 && !done; n++) begin
         @(negedge SYS_clk);
         if (!bus.MEM_stall) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout: MEM_stall still high after 12 cycles");
      end
      @(posedge SYS_clk);
      #1;
      bus.MEM_read_en      = 1'b0;
      bus.MEM_write_length = 2'd0;
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [1:0] len, input logic sgn,
                          input int nrd, input logic [ADDR_W-1:0] w0, input logic [ADDR_W-1:0] w1,
                          input int stall, input logic [31:0] exp);
      if (nrd > 0) sram_q.push_back(mk(1'b0, w0, 4'h0, 32'h0));
      if (nrd > 1) sram_q.push_back(mk(1'b0, w1, 4'h0, 32'h0));
      stall_q.push_back(stall);
      load_q.push_back(exp);
      bus.MEM_read_address = addr;
      bus.MEM_read_length  = len;
      bus.MEM_read_signed  = sgn;
      bus.MEM_read_en      = 1'b1;
      finish_op();
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data,
                           input int nwr, input logic [ADDR_W-1:0] w0, input logic [3:0] be0,
                           input logic [31:0] wd0, input logic [ADDR_W-1:0] w1,
                           input logic [3:0] be1, input logic [31:0] wd1, input int stall);
      if (nwr > 0) sram_q.push_back(mk(1'b1, w0, be0, wd0));
      if (nwr > 1) sram_q.push_back(mk(1'b1, w1, be1, wd1));
      if (stall > 0) stall_q.push_back(stall);
      bus.MEM_write_address = addr;
      bus.MEM_write_length  = len;
      bus.MEM_write_data    = data;
      finish_op();
   endtask

   initial begin
      SYS_reset_n           = 1'b1;
      bus.MEM_read_en       = 1'b0;
      bus.MEM_read_length   = 2'd0;
      bus.MEM_read_signed   = 1'b0;
      bus.MEM_read_address  = 32'd0;
      bus.MEM_write_length  = 2'd0;
      bus.MEM_write_data    = 32'd0;
      bus.MEM_write_address = 32'd0;
      #3;
      SYS_reset_n = 1'b0;
      // a pending load must not reach the SRAM while reset is held
      bus.MEM_read_en      = 1'b1;
      bus.MEM_read_length  = 2'd3;
      bus.MEM_read_address = 32'h0000_0014;
      repeat (3) @(negedge SYS_clk);
      chk("rst_sram_en", 32'(bus.SRAM_en), 32'd0);
      chk("rst_sram_we", 32'(bus.SRAM_we), 32'd0);
      chk("rst_sram_be", 32'(bus.SRAM_be), 32'd0);
      chk("rst_stall", 32'(bus.MEM_stall), 32'd0);
      chk("rst_read_data", bus.MEM_read_data, 32'd0);

      // release: the held load reads word 5 straight away
      sram_q.push_back(mk(1'b0, 10'd5, 4'h0, 32'h0));
      stall_q.push_back(2);
      load_q.push_back(32'hCAFE_F00D);
      @(posedge SYS_clk);
      #1;
      SYS_reset_n = 1'b1;
      mon_en      = 1'b1;
      finish_op();

      // aligned word store and load back
      do_store(32'h10, 2'd3, 32'hDEAD_BEEF, 1, 10'd4, 4'b1111, 32'hDEAD_BEEF, 10'd0, 4'h0, 32'h0, 0);
      do_load (32'h10, 2'd3, 1'b0, 1, 10'd4, 10'd0, 2, 32'hDEAD_BEEF);
      // byte and half loads with both extensions
      do_load (32'h13, 2'd1, 1'b1, 1, 10'd4, 10'd0, 2, 32'hFFFF_FFDE);
      do_load (32'h13, 2'd1, 1'b0, 1, 10'd4, 10'd0, 2, 32'h0000_00DE);
      do_load (32'h12, 2'd2, 1'b1, 1, 10'd4, 10'd0, 2, 32'hFFFF_DEAD);
      do_load (32'h10, 2'd2, 1'b0, 1, 10'd4, 10'd0, 2, 32'h0000_BEEF);
      // byte store into lane 1, word becomes 0xDEAD5AEF
      do_store(32'h11, 2'd1, 32'h0000_005A, 1, 10'd4, 4'b0010, 32'h0000_5A00, 10'd0, 4'h0, 32'h0, 0);
      do_load (32'h10, 2'd0, 1'b0, 1, 10'd4, 10'd0, 2, 32'hDEAD_5AEF);
      // load and store together: only the load happens
      bus.MEM_write_address = 32'h10;
      bus.MEM_write_data    = 32'h1234_5678;
      bus.MEM_write_length  = 2'd3;
      do_load (32'h10, 2'd3, 1'b0, 1, 10'd4, 10'd0, 2, 32'hDEAD_5AEF);
      do_load (32'h10, 2'd2, 1'b0, 1, 10'd4, 10'd0, 2, 32'h0000_5AEF);
      // byte-address bits above the SRAM range are ignored
      do_load (32'hFFFF_F010, 2'd3, 1'b0, 1, 10'd4, 10'd0, 2, 32'hDEAD_5AEF);

`ifndef DMEM_MISALIGN_TRAP_EN
      // split word store across words 3/4, then split load back
      do_store(32'h0E, 2'd3, 32'h1122_3344, 2, 10'd3, 4'b1100, 32'h3344_0000,
               10'd4, 4'b0011, 32'h0000_1122, 1);
      do_load (32'h0E, 2'd3, 1'b0, 2, 10'd3, 10'd4, 3, 32'h1122_3344);
      do_load (32'h10, 2'd3, 1'b0, 1, 10'd4, 10'd0, 2, 32'hDEAD_1122);
      // split half store at offset 3
      do_store(32'h3FF, 2'd2, 32'h0000_8001, 2, 10'd255, 4'b1000, 32'h0100_0000,
               10'd256, 4'b0001, 32'h0000_0080, 1);
      do_load (32'h3FF, 2'd2, 1'b1, 2, 10'd255, 10'd256, 3, 32'hFFFF_8001);
      do_load (32'h3FF, 2'd2, 1'b0, 2, 10'd255, 10'd256, 3, 32'h0000_8001);
      // top-of-memory half load wraps to word 0: bytes A5 (word 1023) and F0 (word 0)
      do_load (32'h0000_0FFF, 2'd2, 1'b1, 2, 10'd1023, 10'd0, 3, 32'hFFFF_F0A5);
`else
      // misaligned load: flagged, no SRAM access, completes with zero
      mis_q.push_back(1);
      do_load (32'h01, 2'd3, 1'b0, 0, 10'd0, 10'd0, 2, 32'h0000_0000);
      // misaligned store: flagged and dropped without a stall
      mis_q.push_back(1);
      do_store(32'h02, 2'd3, 32'h7777_7777, 0, 10'd0, 4'h0, 32'h0, 10'd0, 4'h0, 32'h0, 0);
      do_load (32'h00, 2'd3, 1'b0, 1, 10'd0, 10'd0, 2, 32'h0000_00F0);
`endif

      // quiet bus: any strobe now would be unexpected
      repeat (5) @(posedge SYS_clk);
      @(negedge SYS_clk);
      chk("left_sram_exp", 32'(sram_q.size()), 32'd0);
      chk("left_stall_exp", 32'(stall_q.size()), 32'd0);
      chk("left_load_exp", 32'(load_q.size()), 32'd0);
      chk("left_mis_exp", 32'(mis_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Load/store unit between DATA_PATH memory outputs and a word-wide synchronous data SRAM.
- Converts byte/half/word requests with arbitrary byte addresses into word-aligned SRAM accesses with byte enables.
- Sign/zero-extends load data and splits misaligned accesses into two word accesses.
- Holds the PC via MEM_stall while a multi-cycle access is in flight.

Parameters:
- ADDR_W, 10, SRAM word-address width (2^ADDR_W words). Upper byte-address bits beyond ADDR_W+2 are ignored, so addresses wrap.

Ports:
- SYS_clk  in  1  system clock, rising edge
- SYS_reset_n  in  1  asynchronous, active-low reset
- MEM_read_en  in  1  load request (opcode 0000011)
- MEM_read_length  in  2  1=byte, 2=half, 3=word; 0 treated as word
- MEM_read_signed  in  1  sign-extend byte/half loads
- MEM_read_address  in  32  load byte address
- MEM_write_length  in  2  0=no store, 1=byte, 2=half, 3=word
- MEM_write_data  in  32  store data, LSB-aligned
- MEM_write_address  in  32  store byte address
- MEM_read_data  out  32  extended load result; valid in DONE
- MEM_stall  out  1  hold PC / suppress register write-back
- SRAM_en  out  1  SRAM access strobe
- SRAM_we  out  1  SRAM write (1) / read (0)
- SRAM_addr  out  ADDR_W  SRAM word address
- SRAM_be  out  4  byte enables, bit i = byte lane i (little-endian)
- SRAM_wdata  out  32  lane-aligned write data
- SRAM_rdata  in  32  read data, valid the cycle after a read strobe

Behaviour:
- States: IDLE, RD1, RD2, WR2, DONE. Reset: state=IDLE, MEM_read_data=0, internal word buffers=0.
- While SYS_reset_n=0: SRAM_en=0, SRAM_we=0, SRAM_be=0, MEM_stall=0, regardless of inputs.
- Access geometry:
  - off = addr[1:0], nbytes = 1/2/4, word0 = addr[ADDR_W+1:2], word1 = word0+1 (mod 2^ADDR_W).
  - A request is split when off+nbytes > 4: half at off 3; word at off 1..3.
- Request decode in IDLE:
  - If MEM_read_en=1, it is a read and any simultaneous store is dropped.
  - Otherwise MEM_write_length!=0 is a write.
- IDLE read, both aligned and split:
  - Drive SRAM_en=1, SRAM_we=0, SRAM_addr=word0 combinationally; MEM_stall=1.
  - Next state RD1.
- RD1:
  - Capture SRAM_rdata into buffer0. MEM_stall=1.
  - If split: issue read of word1 and go to RD2. Otherwise go to DONE.
- RD2: capture SRAM_rdata into buffer1; MEM_stall=1; go to DONE.
- Load result:
  - Extracted bytes are {buffer1,buffer0} >> (8*off), truncated to nbytes.
  - Extended per MEM_read_signed; word loads are never extended.
  - Registered into MEM_read_data on entry to DONE.
- DONE: MEM_stall=0, so the CPU commits rd and advances the PC on this edge. Next state is IDLE unconditionally; the still-present request is not re-accepted.
- Load latency: aligned 3 cycles (2 stalled); split 4 cycles (3 stalled).
- IDLE aligned write:
  - SRAM_en=1, SRAM_we=1, SRAM_addr=word0.
  - SRAM_be = lane mask shifted by off; SRAM_wdata = MEM_write_data << (8*off).
  - MEM_stall=0; stays in IDLE (single cycle).
- IDLE split write:
  - Write the low part to word0 with the truncated be/wdata; MEM_stall=1; go to WR2.
- WR2:
  - Write the high part to word1: SRAM_be = mask >> (4-off), SRAM_wdata = MEM_write_data >> (8*(4-off)).
  - MEM_stall=0; go to IDLE.
- No request in IDLE: SRAM_en=0, MEM_stall=0.
- Reset asserted mid-operation: immediate return to IDLE. No partial second access is issued after release. A half-completed split store remains half-written.
- MEM_read_data holds its last value outside DONE.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- When defined:
  - Split requests are not performed; no SRAM strobe is issued.
  - An extra output MEM_misaligned (1 bit) pulses high for one cycle, combinationally in IDLE.
  - Misaligned loads complete through DONE with MEM_read_data=0 (IDLE→RD1→DONE, no SRAM access).
  - Misaligned stores are dropped with MEM_stall=0.
- When undefined: the port is absent and splitting behaves as above.

Test Plan:
- Reset: hold SYS_reset_n=0 with MEM_read_en=1 → SRAM_en=0, MEM_stall=0, MEM_read_data=0; release → read of word0 issued next cycle.
- Aligned word store then load:
  - Store 0xDEADBEEF, length 3, to address 0x10 → SRAM_addr=4, be=1111, no stall.
  - Load word from 0x10 → MEM_stall high for 2 cycles, then MEM_read_data=0xDEADBEEF in DONE.
- Byte loads from 0x13 holding 0xDE: lb → 0xFFFFFFDE; lbu → 0x000000DE; each 3 cycles.
- Misaligned word store of 0x11223344 to 0x0E:
  - Cycle 1: word 3, be=1100, wdata=0x33440000.
  - Cycle 2: word 4, be=0011, wdata=0x00001122.
  - Word load from 0x0E then returns 0x11223344 after 3 stall cycles.
- Wrap: signed half load from byte address (2^ADDR_W*4 − 1) → second read targets SRAM_addr=0; result is correctly sign-extended.
- Simultaneous MEM_read_en=1 and MEM_write_length=3 → no SRAM_we asserted, read serviced. With DMEM_MISALIGN_TRAP_EN, a word load at 0x01 gives MEM_misaligned=1 and a result of 0.
